// File: rtl/dmi_cmd_master.sv
// dmi_cmd_master: single-outstanding DMI requester with per-attempt timeout and busy retry.
module dmi_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RETRY_MAX      = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [6:0]  cmd_addr_i,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [1:0]  rsp_resp_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [6:0]  dmi_req_bits_addr_o,
    output logic [1:0]  dmi_req_bits_op_o,
    output logic [31:0] dmi_req_bits_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [1:0]  dmi_resp_bits_resp_i,
    input  logic [31:0] dmi_resp_bits_data_i,
    output logic        busy_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [6:0]    addr_q, addr_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    resp_q, resp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          to_q, to_d;
    logic          timer_hit;

    assign timer_hit = timer_q == TMAX;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                addr_d  = cmd_addr_i;
                op_d    = cmd_op_i;
                wdata_d = cmd_data_i;
                timer_d = '0;
                retry_d = '0;
                state_d = REQ;
            end
            REQ: begin
                timer_d = timer_q + 1'b1;
                if (dmi_req_ready_i) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else if (timer_hit) begin
                    resp_d  = 2'd2;
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = RSP;
                end
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // a real response in the timeout cycle takes precedence over the abort
                if (dmi_resp_valid_i && dmi_resp_bits_resp_i == 2'd3 && retry_q < RMAX) begin
                    retry_d = retry_q + 1'b1;
                    timer_d = '0;
                    state_d = REQ;
                end else if (dmi_resp_valid_i) begin
                    resp_d  = dmi_resp_bits_resp_i;
                    rdata_d = dmi_resp_bits_data_i;
                    to_d    = 1'b0;
                    state_d = RSP;
                end else if (timer_hit) begin
                    resp_d  = 2'd2;
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: state_d = rsp_ready_i ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    // outputs decode from state only, so an async reset clears them immediately
    assign cmd_ready_o         = state_q == IDLE;
    assign busy_o              = state_q != IDLE;
    assign dmi_req_valid_o     = state_q == REQ;
    assign dmi_req_bits_addr_o = dmi_req_valid_o ? addr_q : '0;
    assign dmi_req_bits_op_o   = dmi_req_valid_o ? op_q : '0;
    assign dmi_req_bits_data_o = dmi_req_valid_o ? wdata_q : '0;
    assign dmi_resp_ready_o    = state_q == WAIT;
    assign rsp_valid_o         = state_q == RSP;
    assign rsp_resp_o          = rsp_valid_o ? resp_q : '0;
    assign rsp_data_o          = rsp_valid_o ? rdata_q : '0;
    assign rsp_timeout_o       = rsp_valid_o & to_q;
endmodule

// File: tb/tb_dmi_cmd_master.sv
// tb_dmi_cmd_master: directed checks of dmi_cmd_master with TIMEOUT_CYCLES=16, RETRY_MAX=3.
module tb_dmi_cmd_master;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [6:0]  cmd_addr_i = '0;
    logic [1:0]  cmd_op_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [1:0]  rsp_resp_o;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i = 1'b0;
    logic [6:0]  dmi_req_bits_addr_o;
    logic [1:0]  dmi_req_bits_op_o;
    logic [31:0] dmi_req_bits_data_o;
    logic        dmi_resp_valid_i = 1'b0;
    logic        dmi_resp_ready_o;
    logic [1:0]  dmi_resp_bits_resp_i = '0;
    logic [31:0] dmi_resp_bits_data_i = '0;
    logic        busy_o;

    int n_run = 0;
    int n_fail = 0;
    int req_hs = 0;

    dmi_cmd_master #(.TIMEOUT_CYCLES(16), .RETRY_MAX(3)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_resp_o(rsp_resp_o), .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_bits_addr_o(dmi_req_bits_addr_o), .dmi_req_bits_op_o(dmi_req_bits_op_o),
        .dmi_req_bits_data_o(dmi_req_bits_data_o),
        .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_bits_resp_i(dmi_resp_bits_resp_i), .dmi_resp_bits_data_i(dmi_resp_bits_data_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // inputs only change just after a rising edge, so the falling edge sees what the next edge will
    always @(negedge clk) if (dmi_req_valid_o && dmi_req_ready_i) req_hs++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        check("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        tick;
        cmd_valid_i = 1'b0;
        check("req_valid_n1", 32'(dmi_req_valid_o), 32'd1);
        check("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
    endtask

    task automatic respond(input logic [1:0] resp, input logic [31:0] data);
        dmi_resp_valid_i     = 1'b1;
        dmi_resp_bits_resp_i = resp;
        dmi_resp_bits_data_i = data;
        tick;
        dmi_resp_valid_i     = 1'b0;
        dmi_resp_bits_resp_i = '0;
        dmi_resp_bits_data_i = '0;
    endtask

    task automatic consume(input logic [1:0] resp, input logic [31:0] data, input logic to);
        check("rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("rsp_resp", 32'(rsp_resp_o), 32'(resp));
        check("rsp_data", rsp_data_o, data);
        check("rsp_timeout", 32'(rsp_timeout_o), 32'(to));
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        check("rsp_done", 32'(rsp_valid_o), 32'd0);
        check("idle_ready", 32'(cmd_ready_o), 32'd1);
    endtask

    initial begin
        int base;
        int cnt;
        #12;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_req_valid", 32'(dmi_req_valid_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_resp_ready", 32'(dmi_resp_ready_o), 32'd0);
        check("rst_rsp_data", rsp_data_o, 32'd0);
        tick;
        rst_ni = 1'b1;
        tick;
        check("post_rst_ready", 32'(cmd_ready_o), 32'd1);

        // read ok, response two cycles into WAIT
        dmi_req_ready_i = 1'b1;
        send_cmd(2'd1, 7'h11, 32'h0);
        check("rd_addr", 32'(dmi_req_bits_addr_o), 32'h11);
        check("rd_op", 32'(dmi_req_bits_op_o), 32'd1);
        check("busy", 32'(busy_o), 32'd1);
        tick;
        dmi_req_ready_i = 1'b0;
        check("rd_wait", 32'(dmi_resp_ready_o), 32'd1);
        check("rd_req_drop", 32'(dmi_req_valid_o), 32'd0);
        tick;
        tick;
        respond(2'd0, 32'h00C0FFEE);
        check("rd_resp_ready_drop", 32'(dmi_resp_ready_o), 32'd0);
        consume(2'd0, 32'h00C0FFEE, 1'b0);

        // write with request backpressure and response backpressure
        base = req_hs;
        send_cmd(2'd2, 7'h10, 32'h80000001);
        for (int i = 0; i < 5; i++) begin
            check("wr_valid_hold", 32'(dmi_req_valid_o), 32'd1);
            check("wr_addr_hold", 32'(dmi_req_bits_addr_o), 32'h10);
            check("wr_op_hold", 32'(dmi_req_bits_op_o), 32'd2);
            check("wr_data_hold", dmi_req_bits_data_o, 32'h80000001);
            tick;
        end
        dmi_req_ready_i = 1'b1;
        tick;
        dmi_req_ready_i = 1'b0;
        check("wr_one_hs", 32'(req_hs - base), 32'd1);
        respond(2'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("wr_rsp_hold_v", 32'(rsp_valid_o), 32'd1);
            check("wr_rsp_hold_r", 32'(rsp_resp_o), 32'd0);
            check("wr_rsp_hold_t", 32'(rsp_timeout_o), 32'd0);
            tick;
        end
        consume(2'd0, 32'h0, 1'b0);

        // busy twice then ok: three request handshakes
        base = req_hs;
        dmi_req_ready_i = 1'b1;
        send_cmd(2'd1, 7'h05, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            respond(i < 2 ? 2'd3 : 2'd0, 32'hA5A5_0000 + 32'(i));
            if (i < 2) check("retry_req_next", 32'(dmi_req_valid_o), 32'd1);
        end
        dmi_req_ready_i = 1'b0;
        check("retry_hs3", 32'(req_hs - base), 32'd3);
        consume(2'd0, 32'hA5A5_0002, 1'b0);

        // always busy: RETRY_MAX re-issues then busy is reported
        base = req_hs;
        dmi_req_ready_i = 1'b1;
        send_cmd(2'd1, 7'h06, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick;
            respond(2'd3, 32'h0000_BB00 + 32'(i));
        end
        dmi_req_ready_i = 1'b0;
        check("busy_hs4", 32'(req_hs - base), 32'd4);
        consume(2'd3, 32'h0000_BB03, 1'b0);

        // timeout in REQ
        send_cmd(2'd1, 7'h07, 32'h0);
        cnt = 0;
        for (int i = 0; i < 40 && dmi_req_valid_o; i++) begin
            cnt++;
            tick;
        end
        check("to_req_cycles", 32'(cnt), 32'd16);
        consume(2'd2, 32'h0, 1'b1);

        // timeout in WAIT
        dmi_req_ready_i = 1'b1;
        send_cmd(2'd1, 7'h08, 32'h0);
        tick;
        dmi_req_ready_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && dmi_resp_ready_o; i++) begin
            cnt++;
            tick;
        end
        check("to_wait_cycles", 32'(cnt), 32'd16);
        consume(2'd2, 32'h0, 1'b1);

        // response lands in the last WAIT cycle
        dmi_req_ready_i = 1'b1;
        send_cmd(2'd1, 7'h09, 32'h0);
        tick;
        dmi_req_ready_i = 1'b0;
        repeat (15) tick;
        check("prec_wait_alive", 32'(dmi_resp_ready_o), 32'd1);
        respond(2'd0, 32'h12345678);
        consume(2'd0, 32'h12345678, 1'b0);

        // request ready lands in the last REQ cycle
        send_cmd(2'd2, 7'h0A, 32'h5);
        repeat (15) tick;
        check("prec_req_alive", 32'(dmi_req_valid_o), 32'd1);
        dmi_req_ready_i = 1'b1;
        tick;
        dmi_req_ready_i = 1'b0;
        check("prec_req_wait", 32'(dmi_resp_ready_o), 32'd1);
        check("prec_req_no_rsp", 32'(rsp_valid_o), 32'd0);
        respond(2'd0, 32'h0);
        consume(2'd0, 32'h0, 1'b0);

        // asynchronous reset during WAIT
        dmi_req_ready_i = 1'b1;
        send_cmd(2'd1, 7'h0B, 32'h0);
        tick;
        dmi_req_ready_i = 1'b0;
        tick;
        #2 rst_ni = 1'b0;
        #1;
        check("arst_resp_ready", 32'(dmi_resp_ready_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_req_valid", 32'(dmi_req_valid_o), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        dmi_resp_valid_i     = 1'b1;
        dmi_resp_bits_resp_i = 2'd0;
        dmi_resp_bits_data_i = 32'hDEAD_BEEF;
        tick;
        rst_ni = 1'b1;
        tick;
        check("late_resp_ignored", 32'(dmi_resp_ready_o), 32'd0);
        check("late_resp_no_rsp", 32'(rsp_valid_o), 32'd0);
        dmi_resp_valid_i     = 1'b0;
        dmi_resp_bits_data_i = '0;
        dmi_req_ready_i = 1'b1;
        send_cmd(2'd1, 7'h0C, 32'h0);
        tick;
        dmi_req_ready_i = 1'b0;
        respond(2'd0, 32'h0BAD_F00D);
        consume(2'd0, 32'h0BAD_F00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
